// File: rtl/seven_segment_pkg.sv
// seven_segment_pkg: FSM states, digit codes, segment patterns and decode helpers for seven_segment_ctrl
package seven_segment_pkg;

   typedef enum logic [1:0] {IDLE, CONVERT, COMMIT} state_t;

   localparam logic [3:0] DIG_DASH  = 4'hA;
   localparam logic [3:0] DIG_BLANK = 4'hF;

   localparam logic [7:0] SEG_0     = 8'b00000011;
   localparam logic [7:0] SEG_1     = 8'b10011111;
   localparam logic [7:0] SEG_2     = 8'b00100101;
   localparam logic [7:0] SEG_3     = 8'b00001101;
   localparam logic [7:0] SEG_4     = 8'b10011001;
   localparam logic [7:0] SEG_5     = 8'b01001001;
   localparam logic [7:0] SEG_6     = 8'b01000001;
   localparam logic [7:0] SEG_7     = 8'b00011111;
   localparam logic [7:0] SEG_8     = 8'b00000001;
   localparam logic [7:0] SEG_9     = 8'b00001001;
   localparam logic [7:0] SEG_DASH  = 8'b11111101;
   localparam logic [7:0] SEG_BLANK = 8'b11111111;

   // Digit codes 0..9 are decimal values, DIG_DASH is a dash, anything else is blank.
   function automatic logic [7:0] seg_of(input logic [3:0] d);
      case (d)
         4'd0:     return SEG_0;
         4'd1:     return SEG_1;
         4'd2:     return SEG_2;
         4'd3:     return SEG_3;
         4'd4:     return SEG_4;
         4'd5:     return SEG_5;
         4'd6:     return SEG_6;
         4'd7:     return SEG_7;
         4'd8:     return SEG_8;
         4'd9:     return SEG_9;
         DIG_DASH: return SEG_DASH;
         default:  return SEG_BLANK;
      endcase
   endfunction

   function automatic int pow10(input int n);
      int p = 1;
      for (int i = 0; i < n; i++) p = p * 10;
      return p;
   endfunction

endpackage

// File: rtl/seven_segment_if.sv
// seven_segment_if: valid/ready value handshake between a producer and seven_segment_ctrl
interface seven_segment_if #(
   parameter int DATA_WIDTH = 14
);
   logic                  in_valid;
   logic                  in_ready;
   logic [DATA_WIDTH-1:0] in_data;

   modport master (output in_valid, output in_data, input in_ready);
   modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/seven_segment_bin2bcd.sv
// seven_segment_bin2bcd: sequential double-dabble, one bit per cycle, done flags the final iteration
module seven_segment_bin2bcd
#(
   parameter int DATA_WIDTH = 14,
   parameter int NUM_DIGITS = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    start,
   input  logic [DATA_WIDTH-1:0]   data,
   output logic                    done,
   output logic [4*NUM_DIGITS-1:0] bcd
);
   localparam int CW = $clog2(DATA_WIDTH + 1);

   logic [DATA_WIDTH-1:0]   sh;
   logic [CW-1:0]           cnt;
   logic [4*NUM_DIGITS-1:0] adj;

   assign done = cnt == CW'(1);

   // add-3 correction on every nibble of 5 or more before the shift
   always_comb begin
      adj = bcd;
      for (int i = 0; i < NUM_DIGITS; i++)
         if (bcd[4*i +: 4] >= 4'd5) adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
   end

   // load on start, then shift one input bit into the BCD register per cycle
   always_ff @(posedge clk) begin
      if (!rst) begin
         sh  <= '0;
         cnt <= '0;
         bcd <= '0;
      end else if (start) begin
         sh  <= data;
         cnt <= CW'(DATA_WIDTH);
         bcd <= '0;
      end else if (cnt != '0) begin
         bcd <= {adj[4*NUM_DIGITS-2:0], sh[DATA_WIDTH-1]};
         sh  <= sh << 1;
         cnt <= cnt - CW'(1);
      end
   end

endmodule

// File: rtl/seven_segment_ctrl.sv
// seven_segment_ctrl: binary-to-BCD multiplexed display driver; SEVEN_SEG_LEADING_ZERO_BLANK_EN blanks leading zeros
module seven_segment_ctrl
   import seven_segment_pkg::*;
#(
   parameter int NUM_DIGITS = 4,
   parameter int DATA_WIDTH = 14,
   parameter int CLK_FREQ   = 125000000,
   parameter int REFRESH_HZ = 1000
) (
   input  logic                  clk,
   input  logic                  rst,
   seven_segment_if.slave        bus,
   output logic                  overflow,
   output logic [NUM_DIGITS-1:0] an_n,
   output logic [7:0]            seg_n
);
   localparam int DWELL_RAW      = CLK_FREQ / (REFRESH_HZ * NUM_DIGITS);
   localparam int DWELL          = DWELL_RAW < 1 ? 1 : DWELL_RAW;
   localparam int DCW            = DWELL > 1 ? $clog2(DWELL) : 1;
   localparam int IW             = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;
   localparam logic [31:0] MAX_V = 32'(pow10(NUM_DIGITS) - 1);

   state_t                  state_q, state_d;
   logic                    ready_q, ovf_q, start, done;
   logic [4*NUM_DIGITS-1:0] bcd;
   logic [3:0]              digit [NUM_DIGITS];
   logic [3:0]              cur;
   logic [IW-1:0]           idx;
   logic [DCW-1:0]          dwell;

   assign bus.in_ready = ready_q;

   seven_segment_bin2bcd #(.DATA_WIDTH(DATA_WIDTH), .NUM_DIGITS(NUM_DIGITS)) u_bin2bcd (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .data  (bus.in_data),
      .done  (done),
      .bcd   (bcd)
   );

   // next state: accept in IDLE, wait for the engine, commit for one cycle
   always_comb begin
      state_d = state_q;
      start   = 1'b0;
      case (state_q)
         IDLE:    begin
            start   = bus.in_valid && ready_q;
            state_d = start ? CONVERT : IDLE;
         end
         CONVERT: state_d = done ? COMMIT : CONVERT;
         default: state_d = IDLE;
      endcase
   end

   // state register; ready is registered so it stays low throughout reset
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= IDLE;
         ready_q <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         ready_q <= state_d == IDLE;
         if (start) ovf_q <= 32'(bus.in_data) > MAX_V;
      end
   end

   // commit BCD nibbles, or dashes when the captured value did not fit
   always_ff @(posedge clk) begin
      if (!rst) begin
         overflow <= 1'b0;
         for (int i = 0; i < NUM_DIGITS; i++) digit[i] <= 4'd0;
      end else if (state_q == COMMIT) begin
         overflow <= ovf_q;
         for (int i = 0; i < NUM_DIGITS; i++) digit[i] <= ovf_q ? DIG_DASH : bcd[4*i +: 4];
      end
   end

   // dwell counter and digit index, free-running regardless of the FSM
   always_ff @(posedge clk) begin
      if (!rst) begin
         dwell <= '0;
         idx   <= '0;
      end else if (dwell == DCW'(DWELL - 1)) begin
         dwell <= '0;
         idx   <= idx == IW'(NUM_DIGITS - 1) ? '0 : idx + IW'(1);
      end else begin
         dwell <= dwell + DCW'(1);
      end
   end

`ifdef SEVEN_SEG_LEADING_ZERO_BLANK_EN
   logic [NUM_DIGITS-1:0] keep;
   // a digit is shown if it or any more significant digit is non-zero; digit 0 always shows
   always_comb begin
      keep = '0;
      keep[NUM_DIGITS-1] = NUM_DIGITS == 1 || digit[NUM_DIGITS-1] != 4'd0;
      for (int i = NUM_DIGITS - 2; i >= 0; i--) keep[i] = i == 0 || keep[i+1] || digit[i] != 4'd0;
      cur = keep[idx] ? digit[idx] : DIG_BLANK;
   end
`else
   assign cur = digit[idx];
`endif

   // registered pin drivers, one cycle behind the index
   always_ff @(posedge clk) begin
      if (!rst) begin
         an_n  <= '1;
         seg_n <= SEG_BLANK;
      end else begin
         an_n  <= ~(NUM_DIGITS'(1) << idx);
         seg_n <= seg_of(cur);
      end
   end

endmodule

// File: doc/seven_segment_ctrl.md
# seven_segment_ctrl

Display controller for the multiplexed seven-segment display. It accepts a binary value over a valid/ready handshake and converts it to BCD with a sequential double-dabble engine. It latches the digits and time-multiplexes them onto shared segment lines and active-low digit enables. It sits between any value producer (counter, register file, debug tap) and the board's display pins.

## Interface
- `NUM_DIGITS`, 4, number of display digits scanned.
- `DATA_WIDTH`, 14, width of the binary input value.
- `CLK_FREQ`, 125000000, clock frequency in Hz.
- `REFRESH_HZ`, 1000, full-frame refresh rate in Hz.
- `clk`  in  1  single clock, all logic on rising edge.
- `rst`  in  1  reset, synchronous and active-low.
- `in_valid`  in  1  producer has a value.
- `in_ready`  out  1  controller can accept a value.
- `in_data`  in  DATA_WIDTH  unsigned binary value to display.
- `overflow`  out  1  last committed value exceeded 10^NUM_DIGITS-1.
- `an_n`  out  NUM_DIGITS  digit enables, active-low, one-hot-low while scanning.
- `seg_n`  out  8  segments {a,b,c,d,e,f,g,dp}, active-low.

## Operation
- FSM states:
  - IDLE: `in_ready`=1.
  - CONVERT: `in_ready`=0.
  - COMMIT: `in_ready`=0.
- Transitions:
  - IDLE→CONVERT on `in_valid && in_ready`. Capture `in_data`; capture `ovf = (in_data > 10^NUM_DIGITS-1)`.
  - CONVERT runs exactly DATA_WIDTH iterations. Each iteration adds 3 to every nibble ≥5 of the 4*NUM_DIGITS-bit BCD register, then shifts left one bit with the next MSB of the captured value.
  - CONVERT→COMMIT after the last iteration.
  - COMMIT→IDLE. Load the digit registers and `overflow`:
    - ovf=0: digit registers take the BCD nibbles.
    - ovf=1: digit registers are marked dash; BCD result discarded.
- Scan:
  - Dwell counter counts DWELL = max(1, CLK_FREQ/(REFRESH_HZ*NUM_DIGITS)) cycles. On terminal count it wraps to 0 and the digit index advances.
  - Digit index runs 0..NUM_DIGITS-1 and wraps to 0.
  - Digit 0 is the least significant digit.
- Decode, applied to the digit at the current index:
  - 0..9 = 00000011, 10011111, 00100101, 00001101, 10011001, 01001001, 01000001, 00011111, 00000001, 00001001.
  - Dash = 11111101.
  - Blank = 11111111.
- `an_n` = all ones except bit[index]=0.
- Scanning is independent of the FSM. A commit changes digit content mid-frame with no frame synchronisation.

## Timing
- Reset values (while `rst`=0 at a clock edge):
  - FSM=IDLE, `in_ready`=0.
  - Digit registers=0, `overflow`=0.
  - Index=0, dwell=0.
  - `an_n`=all ones, `seg_n`=8'hFF.
- First cycle after release: `in_ready`=1, `an_n`=~1, `seg_n`=pattern for digit 0.
- `an_n`/`seg_n` are registered, one cycle after the index/digit change.
- Accept at edge k:
  - `in_ready` low from k+1 through k+DATA_WIDTH+1.
  - Digit registers and `overflow` update at edge k+DATA_WIDTH+1.
  - `in_ready` high from k+DATA_WIDTH+2.
- `in_data` is ignored when `in_ready`=0. A held `in_valid` is accepted on the first cycle `in_ready` is high.
- Reset mid-conversion aborts with no commit. All state returns to reset values.

## Configuration
- `SEVEN_SEG_LEADING_ZERO_BLANK_EN` defined:
  - Zero digits above the most significant non-zero digit show blank.
  - Digit 0 always shows its value.
  - Enables still scan.
  - Dash display is unaffected.
- Undefined: all digits show their value, including leading zeros.

## Structure
- `seven_segment_pkg` holds:
  - FSM state enum typedef.
  - Segment constants for 0–9, dash and blank.
  - A function mapping a 4-bit digit to segments.
- One sub-module, `seven_segment_bin2bcd`:
  - Sequential double-dabble engine with start/done.
  - DATA_WIDTH and NUM_DIGITS parameters.
- Top holds the FSM, digit registers, scan counter and output registers.

## Test plan
- Reset: hold `rst`=0 for 5 cycles → `in_ready`=0, `an_n`=4'b1111, `seg_n`=8'hFF. Release → next cycle `in_ready`=1, `an_n`=4'b1110, `seg_n`=00000011.
- Value 1234 (CLK_FREQ=4000, REFRESH_HZ=1000, DWELL=1) → `in_ready` low 15 cycles. Then index 0..3 show 10011001, 00001101, 00100101, 10011111; `overflow`=0.
- Value 12345 → all digits 11111101, `overflow`=1. Then value 9 → `overflow`=0, digit 0=00001001.
- `in_valid` held with 5, then 9 presented during CONVERT → 9 is accepted only on the first `in_ready`=1 cycle after the commit of 5. Final digit 0=00001001.
- Value 42, `rst`=0 on the 5th CONVERT cycle → no commit, all digits 0, `in_ready`=1 one cycle after release.
- Value 7 with macro defined → digits 3..1 show 11111111, digit 0 shows 00011111. Without the macro → digits 3..1 show 00000011.
